// File: rtl/rx_module.sv
// UART receive stage: oversampled, mid-bit sampling deserialiser with
// configurable data length, optional even parity and one or two stop bits.
module rx_module #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int DATA_COUNTER_W  = 3,
    parameter int STOP_CONF_W     = 2,
    parameter int DATA_CONF_W     = 2,
    parameter int SAMPLE_COUNT_W  = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   baud_en_i,
    input  logic                                   rx_en_i,
    input  logic [STOP_CONF_W+DATA_CONF_W:0]       rx_conf_i,
    input  logic                                   rx_fifo_en_i,
    input  logic                                   uart_rx_i,
    output logic [MAX_UART_DATA_W-1:0]             rx_data_o,
    output logic                                   rx_done_o,
    output logic                                   rx_busy_o,
    output logic                                   parity_err_o,
    output logic                                   frame_err_o,
    output logic                                   rx_fifo_push_o
);

    localparam int CONF_W = STOP_CONF_W + DATA_CONF_W + 1;
    localparam logic [SAMPLE_COUNT_W-1:0] MID_START = SAMPLE_COUNT_W'((2 ** (SAMPLE_COUNT_W - 1)) - 1);
    localparam logic [SAMPLE_COUNT_W-1:0] MID_BIT   = {SAMPLE_COUNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [MAX_UART_DATA_W-1:0] d);
        return ^d;
    endfunction

    logic                          sync1_r, sync2_r, prev_r;
    state_t                        state_r, state_nx_s;
    logic [SAMPLE_COUNT_W-1:0]     sample_cnt_r;
    logic [DATA_COUNTER_W-1:0]     bit_cnt_r;
    logic                          stop_cnt_r;
    logic [MAX_UART_DATA_W-1:0]    shreg_r;
    logic [CONF_W-1:0]             conf_r;
    logic                          perr_acc_r, ferr_acc_r;
    logic [MAX_UART_DATA_W-1:0]    rx_data_r;
    logic                          done_r, busy_r, push_r, perr_r, ferr_r;

    logic                          fall_s, mid_s, two_stop_s, par_en_s;
    logic [DATA_COUNTER_W-1:0]     last_idx_s, shift_s;
    logic [MAX_UART_DATA_W-1:0]    aligned_s;
    logic                          busy_s, done_s, push_s;

    assign fall_s     = prev_r & ~sync2_r;
    assign two_stop_s = |conf_r[STOP_CONF_W:1];
    assign par_en_s   = conf_r[0];
    assign last_idx_s = DATA_COUNTER_W'(conf_r[CONF_W-1 -: DATA_CONF_W]) + DATA_COUNTER_W'(4);
    // Bits enter at the MSB, so a short word sits high and is shifted down.
    assign shift_s    = DATA_COUNTER_W'(MAX_UART_DATA_W - 5) - DATA_COUNTER_W'(conf_r[CONF_W-1 -: DATA_CONF_W]);
    assign aligned_s  = shreg_r >> shift_s;

    // Mid-sample strobe: half a bit into START, a full bit in later states.
    always_comb begin
        mid_s = 1'b0;
        if (baud_en_i) begin
            if (state_r == ST_START) begin
                mid_s = (sample_cnt_r == MID_START);
            end else begin
                mid_s = (sample_cnt_r == MID_BIT);
            end
        end else begin
            mid_s = 1'b0;
        end
    end

    // Input synchroniser plus edge-detect history, idle-high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= uart_rx_i;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        if (!rx_en_i && (state_r != ST_IDLE)) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_en_i && fall_s) state_nx_s = ST_START;
                    else                   state_nx_s = ST_IDLE;
                end
                ST_START: begin
                    if (mid_s) state_nx_s = sync2_r ? ST_IDLE : ST_DATA;
                    else       state_nx_s = ST_START;
                end
                ST_DATA: begin
                    if (mid_s && (bit_cnt_r == last_idx_s)) state_nx_s = par_en_s ? ST_PARITY : ST_STOP;
                    else                                   state_nx_s = ST_DATA;
                end
                ST_PARITY: begin
                    if (mid_s) state_nx_s = ST_STOP;
                    else       state_nx_s = ST_PARITY;
                end
                ST_STOP: begin
                    if (mid_s && (stop_cnt_r || !two_stop_s)) state_nx_s = ST_DONE;
                    else                                     state_nx_s = ST_STOP;
                end
                ST_DONE:  state_nx_s = ST_IDLE;
                default:  state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs, decoded from the upcoming state so they can be registered.
    always_comb begin
        busy_s = (state_nx_s != ST_IDLE);
        done_s = (state_nx_s == ST_DONE);
        push_s = (state_nx_s == ST_DONE) & rx_fifo_en_i;
    end

    // Oversample counter: restarts on every state change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_cnt_r <= {SAMPLE_COUNT_W{1'b0}};
        end else if (state_nx_s != state_r) begin
            sample_cnt_r <= {SAMPLE_COUNT_W{1'b0}};
        end else if (baud_en_i) begin
            sample_cnt_r <= sample_cnt_r + SAMPLE_COUNT_W'(1);
        end
    end

    // Frame datapath: config capture, shift register, error accumulation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conf_r     <= {CONF_W{1'b0}};
            shreg_r    <= {MAX_UART_DATA_W{1'b0}};
            bit_cnt_r  <= {DATA_COUNTER_W{1'b0}};
            stop_cnt_r <= 1'b0;
            perr_acc_r <= 1'b0;
            ferr_acc_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && (state_nx_s == ST_START)) begin
            conf_r     <= rx_conf_i;
            shreg_r    <= {MAX_UART_DATA_W{1'b0}};
            bit_cnt_r  <= {DATA_COUNTER_W{1'b0}};
            stop_cnt_r <= 1'b0;
            perr_acc_r <= 1'b0;
            ferr_acc_r <= 1'b0;
        end else if (mid_s) begin
            if (state_r == ST_DATA) begin
                shreg_r   <= {sync2_r, shreg_r[MAX_UART_DATA_W-1:1]};
                bit_cnt_r <= bit_cnt_r + DATA_COUNTER_W'(1);
            end
            if (state_r == ST_PARITY) begin
                perr_acc_r <= sync2_r ^ even_parity(shreg_r);
            end
            if (state_r == ST_STOP) begin
                ferr_acc_r <= ferr_acc_r | ~sync2_r;
                stop_cnt_r <= 1'b1;
            end
        end
    end

    // Registered outputs; word and flags change together only on completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_data_r <= {MAX_UART_DATA_W{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            push_r    <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            done_r <= done_s;
            busy_r <= busy_s;
            push_r <= push_s;
            if (done_s) begin
                rx_data_r <= aligned_s;
                perr_r    <= perr_acc_r;
                ferr_r    <= ferr_acc_r | ~sync2_r;
            end
        end
    end

    assign rx_data_o      = rx_data_r;
    assign rx_done_o      = done_r;
    assign rx_busy_o      = busy_r;
    assign parity_err_o   = perr_r;
    assign frame_err_o    = ferr_r;
    assign rx_fifo_push_o = push_r;

endmodule

// File: tb/tb_rx_module.sv
// Self-checking bench for rx_module: a frame-level scoreboard checked every
// cycle, plus directed literal expectations for each scenario.
module tb_rx_module;

    logic       clk = 1'b0;
    logic       rst_i, baud_en_i, rx_en_i, rx_fifo_en_i, uart_rx_i;
    logic [4:0] rx_conf_i;
    logic [7:0] rx_data_o;
    logic       rx_done_o, rx_busy_o, parity_err_o, frame_err_o, rx_fifo_push_o;

    always #5 clk = ~clk;

    rx_module dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .baud_en_i     (baud_en_i),
        .rx_en_i       (rx_en_i),
        .rx_conf_i     (rx_conf_i),
        .rx_fifo_en_i  (rx_fifo_en_i),
        .uart_rx_i     (uart_rx_i),
        .rx_data_o     (rx_data_o),
        .rx_done_o     (rx_done_o),
        .rx_busy_o     (rx_busy_o),
        .parity_err_o  (parity_err_o),
        .frame_err_o   (frame_err_o),
        .rx_fifo_push_o(rx_fifo_push_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       push;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_cur;
    logic [7:0] m_data = 8'h00;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;
    bit         armed = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_done = 0;
    int         n_push = 0;
    int         done_cyc = 0;
    int         fall_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // par: 0 none, 1 correct even parity, 2 inverted parity bit
    task automatic send_frame(input logic [7:0] d, input int nbits, input int par,
                              input int nstop, input bit stop_bad, input bit push_exp);
        exp_t       e;
        logic [7:0] m;
        logic       pbit;
        m      = 8'hFF >> (8 - nbits);
        e.data = d & m;
        e.perr = (par == 2);
        e.ferr = stop_bad;
        e.push = push_exp;
        exp_q.push_back(e);
        fall_cyc  = cyc;
        uart_rx_i = 1'b0;
        tick(16);
        for (int i = 0; i < nbits; i++) begin
            uart_rx_i = d[i];
            tick(16);
        end
        if (par != 0) begin
            pbit = ^(d & m);
            if (par == 2) pbit = ~pbit;
            uart_rx_i = pbit;
            tick(16);
        end
        for (int i = 0; i < nstop; i++) begin
            uart_rx_i = ~stop_bad;
            tick(16);
        end
        uart_rx_i = ~stop_bad;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst_i) begin
            armed  = 1'b1;
            m_data = 8'h00;
            m_perr = 1'b0;
            m_ferr = 1'b0;
        end
    end

    // Scoreboard compare on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (armed && !rst_i) begin
            if (rx_done_o === 1'b1) begin
                n_done++;
                done_cyc = cyc;
                if (rx_fifo_push_o === 1'b1) n_push++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'd0, rx_done_o}, 32'd0);
                end else begin
                    e_cur  = exp_q.pop_front();
                    check("push_on_done", {31'd0, rx_fifo_push_o}, {31'd0, e_cur.push});
                    m_data = e_cur.data;
                    m_perr = e_cur.perr;
                    m_ferr = e_cur.ferr;
                end
            end else begin
                check("push_without_done", {31'd0, rx_fifo_push_o}, 32'd0);
            end
            check("data_model", {24'd0, rx_data_o}, {24'd0, m_data});
            check("perr_model", {31'd0, parity_err_o}, {31'd0, m_perr});
            check("ferr_model", {31'd0, frame_err_o}, {31'd0, m_ferr});
        end
    end

    initial begin
        rst_i        = 1'b1;
        baud_en_i    = 1'b1;
        rx_en_i      = 1'b1;
        rx_fifo_en_i = 1'b0;
        rx_conf_i    = 5'b11000;
        uart_rx_i    = 1'b1;
        tick(3);
        check("rst_data", {24'd0, rx_data_o}, 32'd0);
        check("rst_done", {31'd0, rx_done_o}, 32'd0);
        check("rst_busy", {31'd0, rx_busy_o}, 32'd0);
        check("rst_perr", {31'd0, parity_err_o}, 32'd0);
        check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        check("rst_push", {31'd0, rx_fifo_push_o}, 32'd0);
        rst_i = 1'b0;
        tick(5);

        // 8N1 0xAA: 3 cycles to edge detect + 152 to final stop sample
        send_frame(8'hAA, 8, 0, 1, 1'b0, 1'b0);
        tick(20);
        check("lat_8n1", done_cyc - fall_cyc, 32'd155);
        check("aa_data", {24'd0, rx_data_o}, 32'h0000_00AA);
        check("aa_perr", {31'd0, parity_err_o}, 32'd0);
        check("aa_ferr", {31'd0, frame_err_o}, 32'd0);
        check("aa_busy", {31'd0, rx_busy_o}, 32'd0);

        // 7E2 0x5A: good parity, then inverted parity bit
        rx_conf_i = 5'b10011;
        send_frame(8'h5A, 7, 1, 2, 1'b0, 1'b0);
        tick(20);
        check("5a_data", {24'd0, rx_data_o}, 32'h0000_005A);
        check("5a_perr", {31'd0, parity_err_o}, 32'd0);
        send_frame(8'h5A, 7, 2, 2, 1'b0, 1'b0);
        tick(20);
        check("5a_bad_data", {24'd0, rx_data_o}, 32'h0000_005A);
        check("5a_bad_perr", {31'd0, parity_err_o}, 32'd1);

        // 5N1 0x13 with FIFO push enabled
        rx_conf_i    = 5'b00000;
        rx_fifo_en_i = 1'b1;
        send_frame(8'h13, 5, 0, 1, 1'b0, 1'b1);
        tick(20);
        rx_fifo_en_i = 1'b0;
        check("13_data", {24'd0, rx_data_o}, 32'h0000_0013);
        check("13_perr_cleared", {31'd0, parity_err_o}, 32'd0);
        check("13_push_count", n_push, 32'd1);

        // 8N1 0x3C with a low stop bit, line then held low
        rx_conf_i = 5'b11000;
        send_frame(8'h3C, 8, 0, 1, 1'b1, 1'b0);
        tick(200);
        check("3c_data", {24'd0, rx_data_o}, 32'h0000_003C);
        check("3c_ferr", {31'd0, frame_err_o}, 32'd1);
        check("held_low_done_count", n_done, 32'd5);
        uart_rx_i = 1'b1;
        tick(40);

        // 4-cycle glitch on the idle line
        uart_rx_i = 1'b0;
        tick(4);
        uart_rx_i = 1'b1;
        tick(1);
        check("glitch_busy_hi", {31'd0, rx_busy_o}, 32'd1);
        tick(15);
        check("glitch_busy_lo", {31'd0, rx_busy_o}, 32'd0);
        check("glitch_ferr_kept", {31'd0, frame_err_o}, 32'd1);
        tick(20);

        // Receiver disabled in the middle of a data bit
        uart_rx_i = 1'b0;
        tick(16);
        uart_rx_i = 1'b1;
        tick(24);
        check("abort_busy_before", {31'd0, rx_busy_o}, 32'd1);
        rx_en_i = 1'b0;
        tick(1);
        check("abort_busy_after", {31'd0, rx_busy_o}, 32'd0);
        tick(200);
        rx_en_i = 1'b1;
        tick(10);
        check("abort_data_kept", {24'd0, rx_data_o}, 32'h0000_003C);
        check("abort_done_count", n_done, 32'd5);

        // Reset in the middle of a data bit
        uart_rx_i = 1'b0;
        tick(40);
        rst_i     = 1'b1;
        uart_rx_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check("midrst_busy", {31'd0, rx_busy_o}, 32'd0);
        check("midrst_data", {24'd0, rx_data_o}, 32'd0);
        check("midrst_ferr", {31'd0, frame_err_o}, 32'd0);
        tick(40);

        // Back-to-back 8N1 pair
        send_frame(8'h01, 8, 0, 1, 1'b0, 1'b0);
        send_frame(8'hFE, 8, 0, 1, 1'b0, 1'b0);
        tick(30);
        check("b2b_data", {24'd0, rx_data_o}, 32'h0000_00FE);
        check("total_done_count", n_done, 32'd7);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
